mpi_eth_rx_parser: RTL and testbench

Receive-side deframer for the MPI-over-Ethernet packet stream. It accepts 64-bit AXI-stream beats in the packet format the stimulus side produces: a fixed 4-beat header followed by `size` payload bytes. It extracts the header fields (MAC, IP, rank, type, size, tag, last) into a registered header interface with a valid/ready handshake. It forwards the payload through a one-deep registered AXI-stream stage, regenerating KEEP/LAST from `size`, and flags malformed frames.

---
 rtl/mpi_eth_rx_parser.sv | 178 +++++++++++++++++
 tb/tb_mpi_eth_rx_parser.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpi_eth_rx_parser.sv
// Receive deframer for MPI-over-Ethernet: parses the 4-beat header into a valid/ready
// header port and forwards the payload through a one-deep stage with regenerated KEEP/LAST.
module mpi_eth_rx_parser #(
  parameter int unsigned MAX_SIZE = 9000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] stream_in_DATA,
  input  logic [7:0]  stream_in_KEEP,
  input  logic        stream_in_LAST,
  input  logic        stream_in_VALID,
  output logic        stream_in_READY,
  output logic [63:0] stream_out_DATA,
  output logic [7:0]  stream_out_KEEP,
  output logic        stream_out_LAST,
  output logic        stream_out_VALID,
  input  logic        stream_out_READY,
  output logic [47:0] mac_dst,
  output logic [47:0] mac_src,
  output logic [15:0] dst,
  output logic [15:0] dst_rank,
  output logic [7:0]  src_rank,
  output logic [7:0]  packet_type,
  output logic [7:0]  tag,
  output logic [31:0] size,
  output logic [31:0] ip_src,
  output logic [31:0] ip_dst,
  output logic        last,
  output logic        hdr_valid,
  input  logic        hdr_ready,
  output logic        err_trunc,
  output logic        err_len,
  output logic        err_size,
  output logic [31:0] pkt_count,
  output logic [15:0] drop_count
);

  typedef enum logic [2:0] {
    StHdr0, StHdr1, StHdr2, StHdr3, StHdrOut, StPayload, StDrain
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] rem_q;
  logic [31:0] beat_size;
  logic        rem_le8;
  logic [7:0]  keep_now;
  logic        in_ready, in_fire;
  logic        err_trunc_d, err_len_d, err_size_d, pkt_inc;
  logic        unused_keep;

  assign unused_keep = ^stream_in_KEEP;
  assign beat_size   = stream_in_DATA[47:16];
  assign rem_le8     = (rem_q <= 32'd8);
  assign keep_now    = rem_le8 ? (8'hFF << (4'd8 - rem_q[3:0])) : 8'hFF;
  // READY is forced low while reset is held.
  assign stream_in_READY = in_ready & ~reset;
  assign in_fire         = stream_in_VALID & stream_in_READY;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StHdr0;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StHdr0: if (in_fire) state_d = stream_in_LAST ? StHdr0 : StHdr1;
      StHdr1: if (in_fire) state_d = stream_in_LAST ? StHdr0 : StHdr2;
      StHdr2: if (in_fire) state_d = stream_in_LAST ? StHdr0 : StHdr3;
      StHdr3: begin
        if (in_fire) begin
          if (beat_size > MAX_SIZE)  state_d = stream_in_LAST ? StHdr0 : StDrain;
          else if (beat_size == '0) state_d = stream_in_LAST ? StHdrOut : StDrain;
          else                       state_d = stream_in_LAST ? StHdr0 : StHdrOut;
        end
      end
      StHdrOut:  if (hdr_ready) state_d = (size == '0) ? StHdr0 : StPayload;
      StPayload: begin
        if (in_fire) begin
          if (stream_in_LAST) state_d = StHdr0;
          else if (rem_le8)   state_d = StDrain;
        end
      end
      StDrain: if (in_fire && stream_in_LAST) state_d = StHdr0;
      default: state_d = StHdr0;
    endcase
  end

  always_comb begin
    in_ready    = 1'b0;
    err_trunc_d = 1'b0;
    err_len_d   = 1'b0;
    err_size_d  = 1'b0;
    pkt_inc     = 1'b0;
    hdr_valid   = (state_q == StHdrOut);
    case (state_q)
      StHdr0, StHdr1, StHdr2: begin
        in_ready    = 1'b1;
        err_trunc_d = in_fire & stream_in_LAST;
      end
      StHdr3: begin
        in_ready = 1'b1;
        if (in_fire) begin
          err_size_d  = (beat_size > MAX_SIZE);
          err_len_d   = (beat_size == '0) & ~stream_in_LAST;
          err_trunc_d = (beat_size <= MAX_SIZE) & (beat_size != '0) & stream_in_LAST;
        end
      end
      StHdrOut: pkt_inc = hdr_ready & (size == '0);
      StPayload: begin
        in_ready = ~stream_out_VALID | stream_out_READY;
        if (in_fire) begin
          pkt_inc     = rem_le8 & stream_in_LAST;
          err_trunc_d = ~rem_le8 & stream_in_LAST;
          err_len_d   = rem_le8 & ~stream_in_LAST;
        end
      end
      StDrain: in_ready = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {mac_dst, mac_src, dst, dst_rank} <= '0;
      {ip_src, ip_dst, src_rank, packet_type, size, tag, last} <= '0;
      rem_q            <= '0;
      stream_out_VALID <= 1'b0;
      stream_out_DATA  <= '0;
      stream_out_KEEP  <= '0;
      stream_out_LAST  <= 1'b0;
      err_trunc        <= 1'b0;
      err_len          <= 1'b0;
      err_size         <= 1'b0;
      pkt_count        <= '0;
      drop_count       <= '0;
    end else begin
      if (in_fire && state_q == StHdr0) begin
        mac_dst         <= stream_in_DATA[63:16];
        mac_src[47:32]  <= stream_in_DATA[15:0];
      end
      if (in_fire && state_q == StHdr1) begin
        mac_src[31:0]   <= stream_in_DATA[63:32];
        dst             <= stream_in_DATA[31:16];
        dst_rank        <= stream_in_DATA[15:0];
      end
      if (in_fire && state_q == StHdr2) begin
        ip_src          <= stream_in_DATA[63:32];
        ip_dst          <= stream_in_DATA[31:0];
      end
      if (in_fire && state_q == StHdr3) begin
        src_rank        <= stream_in_DATA[63:56];
        packet_type     <= stream_in_DATA[55:48];
        size            <= beat_size;
        tag             <= stream_in_DATA[15:8];
        last            <= stream_in_DATA[0];
        rem_q           <= beat_size;
      end
      if (in_fire && state_q == StPayload) begin
        rem_q            <= rem_q - (rem_le8 ? rem_q : 32'd8);
        stream_out_VALID <= 1'b1;
        stream_out_DATA  <= stream_in_DATA;
        stream_out_KEEP  <= keep_now;
        stream_out_LAST  <= rem_le8 | stream_in_LAST;
      end else if (stream_out_READY) begin
        stream_out_VALID <= 1'b0;
      end
      err_trunc <= err_trunc_d;
      err_len   <= err_len_d;
      err_size  <= err_size_d;
      if (pkt_inc) pkt_count <= pkt_count + 32'd1;
      if ((err_trunc_d | err_len_d | err_size_d) && drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mpi_eth_rx_parser.sv
// Directed self-checking bench for mpi_eth_rx_parser.
module tb_mpi_eth_rx_parser;

  localparam logic [47:0] MD = 48'h0A1B2C3D4E5F;
  localparam logic [47:0] MS = 48'h112233445566;
  localparam logic [15:0] DS = 16'hBEEF;
  localparam logic [15:0] DR = 16'h0007;
  localparam logic [31:0] IS = 32'hC0A80001;
  localparam logic [31:0] ID = 32'hC0A80002;
  localparam logic [7:0]  SR = 8'h03;
  localparam logic [7:0]  PT = 8'h5A;
  localparam logic [7:0]  TG = 8'h77;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] stream_in_DATA = '0;
  logic [7:0]  stream_in_KEEP = 8'hFF;
  logic        stream_in_LAST = 1'b0;
  logic        stream_in_VALID = 1'b0;
  logic        stream_in_READY;
  logic [63:0] stream_out_DATA;
  logic [7:0]  stream_out_KEEP;
  logic        stream_out_LAST;
  logic        stream_out_VALID;
  logic        stream_out_READY = 1'b1;
  logic [47:0] mac_dst, mac_src;
  logic [15:0] dst, dst_rank;
  logic [7:0]  src_rank, packet_type, tag;
  logic [31:0] size, ip_src, ip_dst;
  logic        last, hdr_valid;
  logic        hdr_ready = 1'b1;
  logic        err_trunc, err_len, err_size;
  logic [31:0] pkt_count;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;

  logic [63:0] cap_data [0:31];
  logic [7:0]  cap_keep [0:31];
  logic        cap_last [0:31];
  int          cap_n, hs_n, n_trunc, n_len, n_size, stall_viol;
  logic [47:0] h_mac_dst, h_mac_src;
  logic [15:0] h_dst, h_dst_rank;
  logic [7:0]  h_src_rank, h_type, h_tag;
  logic [31:0] h_size, h_ip_src, h_ip_dst;
  logic        h_last;
  bit          tog_en = 1'b0;
  bit          chk_stall = 1'b0;

  always #5 clk = ~clk;

  mpi_eth_rx_parser #(.MAX_SIZE(9000)) dut (
    .clk(clk), .reset(reset),
    .stream_in_DATA(stream_in_DATA), .stream_in_KEEP(stream_in_KEEP),
    .stream_in_LAST(stream_in_LAST), .stream_in_VALID(stream_in_VALID),
    .stream_in_READY(stream_in_READY),
    .stream_out_DATA(stream_out_DATA), .stream_out_KEEP(stream_out_KEEP),
    .stream_out_LAST(stream_out_LAST), .stream_out_VALID(stream_out_VALID),
    .stream_out_READY(stream_out_READY),
    .mac_dst(mac_dst), .mac_src(mac_src), .dst(dst), .dst_rank(dst_rank),
    .src_rank(src_rank), .packet_type(packet_type), .tag(tag), .size(size),
    .ip_src(ip_src), .ip_dst(ip_dst), .last(last),
    .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .err_trunc(err_trunc), .err_len(err_len), .err_size(err_size),
    .pkt_count(pkt_count), .drop_count(drop_count)
  );

  always @(negedge clk) if (tog_en) stream_out_READY = ~stream_out_READY;

  // Samples mid-cycle, after all negedge-driven inputs have settled.
  always @(negedge clk) begin
    #3;
    if (stream_out_VALID && stream_out_READY && cap_n < 32) begin
      cap_data[cap_n] = stream_out_DATA;
      cap_keep[cap_n] = stream_out_KEEP;
      cap_last[cap_n] = stream_out_LAST;
      cap_n++;
    end
    if (hdr_valid && hdr_ready) begin
      hs_n++;
      h_mac_dst = mac_dst; h_mac_src = mac_src; h_dst = dst; h_dst_rank = dst_rank;
      h_ip_src = ip_src; h_ip_dst = ip_dst; h_src_rank = src_rank; h_type = packet_type;
      h_size = size; h_tag = tag; h_last = last;
    end
    if (err_trunc) n_trunc++;
    if (err_len)   n_len++;
    if (err_size)  n_size++;
  end

  task automatic check(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic clear_caps();
    cap_n = 0; hs_n = 0; n_trunc = 0; n_len = 0; n_size = 0; stall_viol = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_beat(input logic [63:0] d, input logic l);
    bit done = 1'b0;
    stream_in_DATA  = d;
    stream_in_LAST  = l;
    stream_in_VALID = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      #1;
      if (chk_stall && stream_out_VALID && !stream_out_READY && stream_in_READY) stall_viol++;
      if (stream_in_READY) done = 1'b1;
      @(negedge clk);
    end
    stream_in_VALID = 1'b0;
    stream_in_LAST  = 1'b0;
    if (!done) check("send_timeout", 64'(done), 64'd1);
  endtask

  task automatic send_hdr(input logic [31:0] sz, input logic l3);
    send_beat({MD, MS[47:32]}, 1'b0);
    send_beat({MS[31:0], DS, DR}, 1'b0);
    send_beat({IS, ID}, 1'b0);
    send_beat({SR, PT, sz, TG, 7'd0, 1'b1}, l3);
  endtask

  initial begin
    clear_caps();
    idle(3);
    check("rst_in_ready", 64'(stream_in_READY), 64'd0);
    check("rst_out_valid", 64'(stream_out_VALID), 64'd0);
    check("rst_out_data", stream_out_DATA, 64'd0);
    check("rst_out_keep_last", 64'({stream_out_KEEP, stream_out_LAST}), 64'd0);
    check("rst_hdr", 64'({hdr_valid, mac_dst, size[7:0]}), 64'd0);
    check("rst_err", 64'({err_trunc, err_len, err_size}), 64'd0);
    check("rst_counts", 64'({pkt_count, drop_count}), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(stream_in_READY), 64'd1);
    @(negedge clk);

    // size=20, three payload beats
    clear_caps();
    send_hdr(32'd20, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(64'hD000_0000_0000_0000 | 64'(i), i == 2);
    idle(3);
    check("t1_hs", 64'(hs_n), 64'd1);
    check("t1_mac_dst", 64'(h_mac_dst), 64'(MD));
    check("t1_mac_src", 64'(h_mac_src), 64'(MS));
    check("t1_dst_rank", 64'({h_dst, h_dst_rank}), 64'({DS, DR}));
    check("t1_ip", {h_ip_src, h_ip_dst}, {IS, ID});
    check("t1_misc", 64'({h_src_rank, h_type, h_tag, h_last}), 64'({SR, PT, TG, 1'b1}));
    check("t1_size", 64'(h_size), 64'd20);
    check("t1_nbeats", 64'(cap_n), 64'd3);
    for (int i = 0; i < 3; i++) check("t1_data", cap_data[i], 64'hD000_0000_0000_0000 | 64'(i));
    check("t1_keep", 64'({cap_keep[0], cap_keep[1], cap_keep[2]}), 64'h00FF_FFF0);
    check("t1_last", 64'({cap_last[0], cap_last[1], cap_last[2]}), 64'b001);
    check("t1_pkt", 64'(pkt_count), 64'd1);
    check("t1_drop", 64'(drop_count), 64'd0);

    // size=0, LAST on header beat 3
    clear_caps();
    send_hdr(32'd0, 1'b1);
    idle(3);
    check("t2_hs", 64'(hs_n), 64'd1);
    check("t2_nbeats", 64'(cap_n), 64'd0);
    check("t2_pkt", 64'(pkt_count), 64'd2);
    check("t2_err", 64'(n_trunc + n_len + n_size), 64'd0);

    // size=64 with output READY toggling every cycle
    clear_caps();
    send_hdr(32'd64, 1'b0);
    tog_en = 1'b1;
    chk_stall = 1'b1;
    for (int i = 0; i < 8; i++) send_beat(64'hA500_0000_0000_0000 | 64'(i), i == 7);
    chk_stall = 1'b0;
    idle(6);
    tog_en = 1'b0;
    stream_out_READY = 1'b1;
    idle(1);
    check("t3_nbeats", 64'(cap_n), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check("t3_data", cap_data[i], 64'hA500_0000_0000_0000 | 64'(i));
      check("t3_keep_last", 64'({cap_keep[i], cap_last[i]}), 64'({8'hFF, i == 7}));
    end
    check("t3_stall", 64'(stall_viol), 64'd0);
    check("t3_pkt", 64'(pkt_count), 64'd3);

    // LAST on header beat 1, then a good size=8 frame
    clear_caps();
    send_beat({MD, MS[47:32]}, 1'b0);
    send_beat({MS[31:0], DS, DR}, 1'b1);
    idle(2);
    check("t4_trunc", 64'(n_trunc), 64'd1);
    check("t4_no_hdr", 64'(hs_n), 64'd0);
    check("t4_drop", 64'(drop_count), 64'd1);
    clear_caps();
    send_hdr(32'd8, 1'b0);
    send_beat(64'h0123_4567_89AB_CDEF, 1'b1);
    idle(3);
    check("t4b_hs_dst", 64'({hs_n[7:0], h_dst, h_size}), 64'({8'd1, DS, 32'd8}));
    check("t4b_beat", 64'(cap_n), 64'd1);
    check("t4b_data", cap_data[0], 64'h0123_4567_89AB_CDEF);
    check("t4b_keep_last", 64'({cap_keep[0], cap_last[0]}), 64'({8'hFF, 1'b1}));
    check("t4b_pkt", 64'(pkt_count), 64'd4);

    // size=16 but four payload beats
    clear_caps();
    send_hdr(32'd16, 1'b0);
    for (int i = 0; i < 4; i++) send_beat(64'hB000_0000_0000_0000 | 64'(i), i == 3);
    idle(3);
    check("t5_nbeats", 64'(cap_n), 64'd2);
    check("t5_last", 64'({cap_last[0], cap_last[1]}), 64'b01);
    check("t5_data1", cap_data[1], 64'hB000_0000_0000_0001);
    check("t5_len", 64'(n_len), 64'd1);
    check("t5_drop", 64'(drop_count), 64'd2);
    check("t5_pkt", 64'(pkt_count), 64'd4);
    check("t5_in_ready", 64'(stream_in_READY), 64'd1);

    // size=MAX_SIZE+1 drained, then a size=4 frame
    clear_caps();
    send_hdr(32'd9001, 1'b0);
    for (int i = 0; i < 3; i++) send_beat(64'hC000_0000_0000_0000 | 64'(i), i == 2);
    idle(3);
    check("t6_size_err", 64'(n_size), 64'd1);
    check("t6_no_out", 64'({hs_n[7:0], cap_n[7:0]}), 64'd0);
    check("t6_drop", 64'(drop_count), 64'd3);
    clear_caps();
    send_hdr(32'd4, 1'b0);
    send_beat(64'h1111_2222_3333_4444, 1'b1);
    idle(3);
    check("t6b_keep_last", 64'({cap_n[7:0], cap_keep[0], cap_last[0]}), 64'({8'd1, 8'hF0, 1'b1}));
    check("t6b_pkt", 64'(pkt_count), 64'd5);

    // Reset mid-payload with a stalled output beat
    clear_caps();
    stream_out_READY = 1'b0;
    send_hdr(32'd24, 1'b0);
    send_beat(64'hEEEE_0000_0000_0001, 1'b0);
    check("t7_held", 64'(stream_out_VALID), 64'd1);
    reset = 1'b1;
    #1;
    check("t7_rst_out", 64'({stream_out_VALID, stream_out_LAST, stream_out_KEEP}), 64'd0);
    check("t7_rst_data", stream_out_DATA, 64'd0);
    check("t7_rst_hdr", 64'({hdr_valid, mac_dst, size[7:0]}), 64'd0);
    check("t7_rst_cnt", 64'({pkt_count, drop_count}), 64'd0);
    check("t7_rst_ready", 64'(stream_in_READY), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stream_out_READY = 1'b1;
    @(negedge clk);
    clear_caps();
    send_hdr(32'd8, 1'b0);
    send_beat(64'h5555_6666_7777_8888, 1'b1);
    idle(3);
    check("t7b_hdr", 64'({hs_n[7:0], h_mac_dst}), 64'({8'd1, MD}));
    check("t7b_data", cap_data[0], 64'h5555_6666_7777_8888);
    check("t7b_pkt", 64'({pkt_count, drop_count}), 64'({32'd1, 16'd0}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
